// File: rtl/dac7611_serial_rx_if.sv
// Three-wire DAC7611 load bus (CS/CLK/SDI plus LD and CLR strobes), all active-low except CLK/SDI.
// The driver side owns every line; the receiver only observes them.
interface dac7611_serial_rx_if;
  logic CS_2;
  logic CLK_3;
  logic SDI_4;
  logic LD_5;
  logic CLR_6;

  modport master (output CS_2, CLK_3, SDI_4, LD_5, CLR_6);
  modport slave  (input  CS_2, CLK_3, SDI_4, LD_5, CLR_6);
endinterface

// File: rtl/dac7611_serial_rx.sv
// Oversampling receiver for the DAC7611 serial load interface: synchronises the bus, deserialises
// DATA_W-bit frames, latches them on LD and flags framing errors and overruns.
module dac7611_serial_rx #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_50M,
  input  logic                locked,
  dac7611_serial_rx_if.slave  bus,
  output logic [DATA_W-1:0]   dac_code,
  output logic                code_valid,
  output logic [4:0]          bit_count,
  output logic                frame_err,
  output logic                overrun,
  output logic                state_dbg
);

  // There is no valid/ready handshake: code_valid is a one-cycle pulse aligned with a new dac_code.
  typedef enum logic {IDLE, SHIFT} state_t;

  // Line order {CS, CLK, SDI, LD, CLR}; reset values match the idle bus.
  localparam logic [4:0] LINE_RST = 5'b10011;
  localparam logic [4:0] FULL     = 5'(DATA_W);

  logic [4:0]                    raw;
  logic [SYNC_STAGES-1:0][4:0]   sync_q, sync_d;
  logic [4:0]                    line_s;
  logic [2:0]                    prev_q, prev_d;
  logic [SYNC_STAGES:0]          fill_q, fill_d;
  state_t                        state_q, state_d;
  logic [DATA_W-1:0]             shift_q, shift_d;
  logic [DATA_W-1:0]             code_q, code_d;
  logic                          valid_q, valid_d;
  logic [4:0]                    count_q, count_d;
  logic                          ferr_q, ferr_d;
  logic                          ovr_q, ovr_d;

  logic cs_s, clk_s, sdi_s, ld_s, clr_s;
  logic armed, cs_fall, cs_rise, clk_rise, ld_fall;
  logic [4:0] cnt;

  assign raw    = {bus.CS_2, bus.CLK_3, bus.SDI_4, bus.LD_5, bus.CLR_6};
  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  assign line_s = sync_q[SYNC_STAGES-1];
  assign {cs_s, clk_s, sdi_s, ld_s, clr_s} = line_s;
  assign prev_d = {cs_s, clk_s, ld_s};
  assign fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};

  // Edges are trusted only once the pipeline holds real samples, so a CS or LD already low at
  // reset release never looks like a falling edge.
  assign armed    = &fill_q;
  assign cs_fall  = armed &  prev_q[2] & ~cs_s;
  assign cs_rise  = armed & ~prev_q[2] &  cs_s;
  assign clk_rise = armed & ~prev_q[1] &  clk_s;
  assign ld_fall  = armed &  prev_q[0] & ~ld_s;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    code_d  = code_q;
    valid_d = 1'b0;
    count_d = count_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    cnt     = count_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt     = '0;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (count_q != FULL) ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A CLK edge in the same cycle as the CS fall counts against the freshly cleared counter.
    if ((state_q == SHIFT || cs_fall) && clk_rise && !cs_s) begin
      shift_d = {shift_q[DATA_W-2:0], sdi_s};
      count_d = (cnt == 5'd31) ? cnt : cnt + 5'd1;
      if (cnt >= FULL) ovr_d = 1'b1;
    end

    if (ld_fall) begin
      if (!cs_s)      ferr_d = 1'b1;
      else if (clr_s) begin
        code_d  = shift_q;
        valid_d = 1'b1;
      end
    end

    if (!clr_s) begin
      code_d  = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_50M or negedge locked) begin
    if (!locked) begin
      sync_q  <= {SYNC_STAGES{LINE_RST}};
      prev_q  <= 3'b101;
      fill_q  <= '0;
      state_q <= IDLE;
      shift_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      count_q <= count_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dac_code   = code_q;
  assign code_valid = valid_q;
  assign bit_count  = count_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign state_dbg  = (state_q == SHIFT);

endmodule

// File: tb/tb_dac7611_serial_rx.sv
// Directed bench for dac7611_serial_rx: drives the serial bus at 1 MHz and checks latched codes,
// pulse counts and sticky flags against hand-computed values.
module tb_dac7611_serial_rx;
  logic        clk_50M;
  logic        locked;
  logic [11:0] dac_code;
  logic        code_valid;
  logic [4:0]  bit_count;
  logic        frame_err;
  logic        overrun;
  logic        state_dbg;

  int checks;
  int errors;
  int valid_cnt;
  int ferr_cnt;
  int v0;
  int f0;

  dac7611_serial_rx_if bus ();

  dac7611_serial_rx #(.DATA_W(12), .SYNC_STAGES(2)) dut (
    .clk_50M    (clk_50M),
    .locked     (locked),
    .bus        (bus.slave),
    .dac_code   (dac_code),
    .code_valid (code_valid),
    .bit_count  (bit_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (code_valid) valid_cnt++;
    if (frame_err)  ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic bus_idle();
    bus.CS_2 = 1'b1; bus.CLK_3 = 1'b0; bus.SDI_4 = 1'b0; bus.LD_5 = 1'b1; bus.CLR_6 = 1'b1;
  endtask

  task automatic send_bits(input logic [15:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.SDI_4 = val[i];
      #250;
      bus.CLK_3 = 1'b1;
      #500;
      bus.CLK_3 = 1'b0;
      #250;
    end
  endtask

  task automatic frame(input logic [15:0] val, input int n);
    bus.CS_2 = 1'b0;
    #500;
    send_bits(val, n);
    #500;
    bus.CS_2 = 1'b1;
    #500;
  endtask

  task automatic ld_pulse();
    @(posedge clk_50M);
    #5 bus.LD_5 = 1'b0;
    #200 bus.LD_5 = 1'b1;
    #300;
  endtask

  initial begin
    checks = 0; errors = 0; valid_cnt = 0; ferr_cnt = 0;
    locked = 1'b0;
    bus_idle();

    // 1: reset held with toggling inputs
    for (int i = 0; i < 8; i++) begin
      bus.CS_2  = 1'($urandom_range(0, 1));
      bus.CLK_3 = 1'($urandom_range(0, 1));
      bus.SDI_4 = 1'($urandom_range(0, 1));
      bus.LD_5  = 1'($urandom_range(0, 1));
      bus.CLR_6 = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk_50M);
      check("reset_outputs", {dac_code, code_valid, frame_err, overrun, bit_count}, 32'h0);
    end
    bus_idle();
    #100 locked = 1'b1;
    repeat (10) @(negedge clk_50M);
    check("post_reset_counts", valid_cnt + ferr_cnt, 0);

    // 2: nominal frame 0xD55, LD latency
    v0 = valid_cnt; f0 = ferr_cnt;
    frame(16'hD55, 12);
    check("nom_bit_count", bit_count, 12);
    @(posedge clk_50M);
    #5 bus.LD_5 = 1'b0;
    repeat (3) @(negedge clk_50M);
    check("nom_code_before", dac_code, 12'h000);
    @(negedge clk_50M);
    check("nom_code_latency", dac_code, 12'hD55);
    check("nom_valid_aligned", code_valid, 1);
    #140 bus.LD_5 = 1'b1;
    #500;
    check("nom_valid_pulses", valid_cnt - v0, 1);
    check("nom_no_frame_err", ferr_cnt - f0, 0);
    check("nom_no_overrun", overrun, 0);

    // 3: short frame of 8 bits
    v0 = valid_cnt; f0 = ferr_cnt;
    frame(16'h00D5, 8);
    check("short_frame_err", ferr_cnt - f0, 1);
    check("short_bit_count", bit_count, 8);
    ld_pulse();
    check("short_code", dac_code, 12'h5D5);
    check("short_valid", valid_cnt - v0, 1);

    // 4: long frame of 14 bits, then CLR
    v0 = valid_cnt; f0 = ferr_cnt;
    frame(16'h3ABC, 14);
    check("long_overrun", overrun, 1);
    check("long_frame_err", ferr_cnt - f0, 1);
    check("long_bit_count", bit_count, 14);
    ld_pulse();
    check("long_code", dac_code, 12'hABC);
    check("long_overrun_sticky", overrun, 1);
    bus.CLR_6 = 1'b0;
    #200 bus.CLR_6 = 1'b1;
    #200;
    check("clr_code", dac_code, 12'h000);
    check("clr_overrun", overrun, 0);

    // 5: LD mid-frame, then LD+CLR together, then a clean LD
    v0 = valid_cnt; f0 = ferr_cnt;
    bus.CS_2 = 1'b0;
    #500;
    send_bits(16'h0007, 4);
    ld_pulse();
    check("midld_frame_err", ferr_cnt - f0, 1);
    check("midld_code", dac_code, 12'h000);
    send_bits(16'h00E1, 8);
    #500 bus.CS_2 = 1'b1;
    #500;
    check("midld_complete_no_err", ferr_cnt - f0, 1);
    @(posedge clk_50M);
    #5 bus.LD_5 = 1'b0; bus.CLR_6 = 1'b0;
    #200 bus.LD_5 = 1'b1; bus.CLR_6 = 1'b1;
    #300;
    check("ldclr_code", dac_code, 12'h000);
    check("ldclr_no_valid", valid_cnt - v0, 0);
    ld_pulse();
    check("after_clr_code", dac_code, 12'h7E1);
    check("after_clr_valid", valid_cnt - v0, 1);

    // 6: reset mid-frame, CS held low through release
    bus.CS_2 = 1'b0;
    #500;
    send_bits(16'h002A, 6);
    locked = 1'b0;
    #100;
    check("midrst_code", dac_code, 12'h000);
    check("midrst_bit_count", bit_count, 0);
    locked = 1'b1;
    #200;
    f0 = ferr_cnt; v0 = valid_cnt;
    send_bits(16'h0003, 2);
    check("cs_low_release_no_frame", bit_count, 0);
    bus.CS_2 = 1'b1;
    #500;
    check("cs_low_release_no_err", ferr_cnt - f0, 0);
    frame(16'h0123, 12);
    ld_pulse();
    check("rst_frame_code", dac_code, 12'h123);
    check("rst_frame_no_err", ferr_cnt - f0, 0);
    check("rst_frame_valid", valid_cnt - v0, 1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac7611_serial_rx.md
Name: dac7611_serial_rx

Overview:
Receive-side model of the DAC7611 3-wire serial load interface, synthesised in the clk_50M domain.
- Oversamples CS/CLK/SDI/LD/CLR as driven by the DAC7611P driver and deserialises the 12-bit word.
- Latches the word on LD and reports it, with framing checks.
- Used on-board for loopback self-test of the DAC driver and as a synthesizable scoreboard front end in simulation.

Parameters:
- DATA_W, 12, shift register and code width (bits per frame).
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input line (minimum 2).

Ports:
- clk_50M  input  1  system clock, 50 MHz.
- locked  input  1  asynchronous active-low reset (PLL lock; 0 holds block in reset).
- CS_2  input  1  chip select, active low.
- CLK_3  input  1  serial clock; data sampled on rising edge.
- SDI_4  input  1  serial data, MSB first.
- LD_5  input  1  load strobe, active low; transfers shift register to output latch.
- CLR_6  input  1  clear, active low; forces output latch to zero.
- dac_code  output  DATA_W  current latched DAC code.
- code_valid  output  1  one-cycle pulse when dac_code updated by LD.
- bit_count  output  5  rising CLK edges seen in the current frame, saturating at 31.
- frame_err  output  1  one-cycle pulse on a framing violation.
- overrun  output  1  sticky; set when a frame has more than DATA_W bits; cleared only by reset or CLR.

Behaviour:
Reset (locked=0, async):
- All sync flops: CS/LD/CLR=1, CLK=0, SDI=0.
- shift_reg=0, dac_code=0, code_valid=0, bit_count=0, frame_err=0, overrun=0.
- State=IDLE.

Input synchronisation and latency:
- Each input passes SYNC_STAGES flops, then one registered copy for edge detection.
- Any edge is acted on SYNC_STAGES+1 clk_50M cycles after the raw input transition.
- The input is required to hold CLK high ≥3 cycles, low ≥3 cycles, and SDI stable ≥3 cycles around the CLK rising edge. Faster input is out of spec; behaviour is undefined.

State machine:
- IDLE -> SHIFT on CS synced falling edge: bit_count<=0; shift_reg retained.
- SHIFT, CLK synced rising edge with CS low:
  - shift_reg <= {shift_reg[DATA_W-2:0], SDI_sync}.
  - bit_count increments, saturating at 31.
  - If bit_count was already DATA_W: set overrun. shift_reg keeps the last DATA_W bits, matching device behaviour.
- SHIFT -> IDLE on CS synced rising edge. If bit_count != DATA_W: frame_err pulse, and shift_reg is still kept.
- CLK edges while CS high are ignored; no shift, no error.

Load, clear and errors:
- LD synced falling edge while CS high and CLR high: dac_code <= shift_reg; code_valid pulses the next cycle, aligned with the new dac_code.
- LD falling while CS low: ignored; frame_err pulse.
- CLR synced low (level): dac_code <= 0 every cycle and overrun <= 0. CLR has priority over LD; no code_valid during CLR.
- LD rising edge has no effect.

Simultaneous events in the same cycle:
- CS rise and LD fall: the CS rise is processed first, and the load uses the completed shift_reg.
- CS fall and CLK rise: bit_count clears, then counts this edge (result 1).
- frame_err from two causes in one cycle: still a single pulse.

Reset mid-frame:
- Immediate return to reset values; the partial frame is discarded.
- After locked rises, the first CS falling edge starts a clean frame. A CS already low at reset release counts as no frame until CS goes high then low again.

Test Plan:
1. Reset held: locked=0 with toggling inputs -> dac_code=0, code_valid=0, frame_err=0, overrun=0 throughout.
2. Nominal frame: locked=1; CS low, 12 bits 0xD55 MSB first at 1 MHz CLK, CS high, LD low pulse 200 ns -> exactly one code_valid pulse, dac_code=0xD55 asserted 3–4 cycles after LD falling edge, frame_err never pulses.
3. Short frame: 8 bits 0xD5, CS high -> one frame_err pulse at CS rise. A following LD gives dac_code={prior shift_reg[3:0],0xD5}; with prior frame 0xD55 the result is 0x5D5.
4. Long frame: 14 bits 0x3ABC (bin 11_1010_1011_1100) then CS high, LD -> overrun=1, frame_err pulse, dac_code=0xABC. A subsequent CLR low clears dac_code to 0 and overrun to 0.
5. LD during CS low plus CLR priority: LD pulse mid-frame -> frame_err pulse, dac_code unchanged. Separately, LD and CLR low together -> dac_code=0, no code_valid.
6. Reset mid-frame: drop locked after 6 bits, release, then send full frame 0x123 + LD -> dac_code=0x123, no frame_err.
